// File: rtl/ula_serial_executor.sv
// Multi-byte serial ALU: one 74181-style 8-bit ALU with its carry chained across beats, LSB byte first.
// Optional macro ULA_SERIAL_ABORT_EN adds an `abort` input that ends a running operation early.

module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       a_eq_b,
  output logic       overflow
);
  logic [7:0] x, y;
  logic [8:0] sum;
  logic       c7;

  always_comb begin
    // 74181 decomposition, active-high data and active-high carry
    x        = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    y        = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
    sum      = {1'b0, x} + {1'b0, y} + {8'd0, c_in};
    c7       = x[7] ^ y[7] ^ sum[7];
    f        = m ? ~(x ^ y) : sum[7:0];
    c_out    = sum[8];
    overflow = ~m & (c7 ^ sum[8]);
    a_eq_b   = &f;
  end
endmodule

module ula_serial_executor #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ULA_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_s,
  input  logic             cmd_m,
  input  logic             cmd_c_in,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_f,
  output logic             out_last,
  output logic             out_c_out,
  output logic             out_a_eq_b,
  output logic             out_overflow
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_f_q, out_f_d;
  logic             out_last_q, out_last_d;
  logic             out_c_q, out_c_d;
  logic             out_eq_q, out_eq_d;
  logic             out_ov_q, out_ov_d;

  logic [7:0] alu_f;
  logic       alu_c, alu_eq, alu_ov;
  logic       abort_run, cmd_fire, in_fire, out_fire, last_beat;

`ifdef ULA_SERIAL_ABORT_EN
  assign abort_run = abort & (state_q == RUN);
`else
  assign abort_run = 1'b0;
`endif

  ula_8_bits u_alu (
    .a        (in_a),
    .b        (in_b),
    .s        (s_q),
    .m        (m_q),
    .c_in     (carry_q),
    .f        (alu_f),
    .c_out    (alu_c),
    .a_eq_b   (alu_eq),
    .overflow (alu_ov)
  );

  assign cmd_ready = ~rst & (state_q == IDLE);
  assign in_ready  = ~rst & (state_q == RUN) & (~out_valid_q | out_ready) & ~abort_run;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign last_beat = (cnt_q == last_q);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    m_d         = m_q;
    carry_d     = carry_q;
    eq_d        = eq_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_f_d     = out_f_q;
    out_last_d  = out_last_q;
    out_c_d     = out_c_q;
    out_eq_d    = out_eq_q;
    out_ov_d    = out_ov_q;

    if (cmd_fire) begin
      state_d = RUN;
      s_d     = cmd_s;
      m_d     = cmd_m;
      carry_d = cmd_c_in;
      eq_d    = 1'b1;
      cnt_d   = '0;
      // store the index of the final beat so length 0 behaves as length 1
      last_d  = (cmd_len == '0) ? '0 : cmd_len - 1'b1;
    end

    if (in_fire) begin
      carry_d     = alu_c;
      eq_d        = eq_q & alu_eq;
      cnt_d       = cnt_q + 1'b1;
      if (last_beat) state_d = IDLE;
      out_valid_d = 1'b1;
      out_f_d     = alu_f;
      out_last_d  = last_beat;
      out_c_d     = alu_c;
      out_eq_d    = eq_q & alu_eq;
      out_ov_d    = alu_ov;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (abort_run) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      eq_q        <= 1'b0;
      cnt_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_last_q  <= 1'b0;
      out_c_q     <= 1'b0;
      out_eq_q    <= 1'b0;
      out_ov_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      m_q         <= m_d;
      carry_q     <= carry_d;
      eq_q        <= eq_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_last_q  <= out_last_d;
      out_c_q     <= out_c_d;
      out_eq_q    <= out_eq_d;
      out_ov_q    <= out_ov_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_f        = out_f_q;
  assign out_last     = out_last_q;
  assign out_c_out    = out_c_q;
  assign out_a_eq_b   = out_eq_q;
  assign out_overflow = out_ov_q;
endmodule

// File: tb/tb_ula_serial_executor.sv
// Self-checking bench for ula_serial_executor: directed vectors plus randomized ops against a wide-arithmetic model.
module tb_ula_serial_executor;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             abort = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_s = '0;
  logic             cmd_m = 1'b0;
  logic             cmd_c_in = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_f;
  logic             out_last, out_c_out, out_a_eq_b, out_overflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_f [16];
  logic       exp_c [16];
  logic       exp_eq[16];
  logic       exp_ov;
  logic [7:0] got_f [16];
  logic       got_c [16];
  logic       got_eq[16];
  logic       got_ov;
  int         got_n;
  int         span;

  ula_serial_executor #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
`ifdef ULA_SERIAL_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_s(cmd_s), .cmd_m(cmd_m),
    .cmd_c_in(cmd_c_in), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_last(out_last),
    .out_c_out(out_c_out), .out_a_eq_b(out_a_eq_b), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Whole-operand model: the 74181 function table applied to N-byte integers.
  task automatic model(input logic [3:0] s, input logic m, input logic cin, input int nb,
                       input logic [127:0] a, input logic [127:0] b);
    logic [127:0] x, y, lg;
    logic [135:0] mask, low;
    logic eq;
    case (s)
      4'h0: begin x = a;      y = '0;     lg = ~a;       end
      4'h1: begin x = a | b;  y = '0;     lg = ~(a | b); end
      4'h2: begin x = a | ~b; y = '0;     lg = ~a & b;   end
      4'h3: begin x = '0;     y = '1;     lg = '0;       end
      4'h4: begin x = a;      y = a & ~b; lg = ~(a & b); end
      4'h5: begin x = a | b;  y = a & ~b; lg = ~b;       end
      4'h6: begin x = a;      y = ~b;     lg = a ^ b;    end
      4'h7: begin x = a & ~b; y = '1;     lg = a & ~b;   end
      4'h8: begin x = a;      y = a & b;  lg = ~a | b;   end
      4'h9: begin x = a;      y = b;      lg = ~(a ^ b); end
      4'hA: begin x = a | ~b; y = a & b;  lg = b;        end
      4'hB: begin x = a & b;  y = '1;     lg = a & b;    end
      4'hC: begin x = a;      y = a;      lg = '1;       end
      4'hD: begin x = a | b;  y = a;      lg = a | ~b;   end
      4'hE: begin x = a | ~b; y = a;      lg = a | b;    end
      default: begin x = a;   y = '1;     lg = a;        end
    endcase
    eq = 1'b1;
    exp_ov = 1'b0;
    for (int k = 0; k < nb; k++) begin
      mask = (136'd1 << (8 * (k + 1))) - 136'd1;
      low  = ({8'd0, x} & mask) + ({8'd0, y} & mask) + {135'd0, cin};
      exp_c[k] = low[8 * (k + 1)];
      exp_f[k] = m ? lg[8 * k +: 8] : low[8 * k +: 8];
      eq = eq & (exp_f[k] == 8'hFF);
      exp_eq[k] = eq;
      if (k == nb - 1)
        exp_ov = !m && (x[8 * k + 7] == y[8 * k + 7]) && (low[8 * k + 7] != x[8 * k + 7]);
    end
  endtask

  task automatic send_cmd(input logic [3:0] s, input logic m, input logic cin, input logic [LEN_W-1:0] len);
    int n = 0;
    cmd_s = s; cmd_m = m; cmd_c_in = cin; cmd_len = len; cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept got=%b exp=1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] s, input logic m, input logic cin, input logic [LEN_W-1:0] len,
                        input logic [127:0] a, input logic [127:0] b, input int vpct, input int rpct);
    int nb, sent, rcv, cyc, first, lastc;
    logic hold;
    logic [7:0] hold_f;
    nb = (len == 0) ? 1 : int'(len);
    sent = 0; rcv = 0; cyc = 0; first = -1; lastc = 0; hold = 1'b0; hold_f = '0;
    model(s, m, cin, nb, a, b);
    send_cmd(s, m, cin, len);
    while (rcv < nb && cyc < 1000) begin
      in_valid = (sent < nb) && ($urandom_range(99) < vpct);
      if (sent < nb) begin
        in_a = a[8 * sent +: 8];
        in_b = b[8 * sent +: 8];
      end
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_f !== hold_f) begin
          failures++;
          $display("FAIL hold_stable got v=%b f=%h exp v=1 f=%h", out_valid, out_f, hold_f);
        end
      end
      if (sent < nb) begin
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
          failures++;
          $display("FAIL in_ready got=%b exp=%b", in_ready, (!out_valid || out_ready));
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({out_f, out_c_out, out_a_eq_b, out_last} !== {exp_f[rcv], exp_c[rcv], exp_eq[rcv], rcv == nb - 1}) begin
          failures++;
          $display("FAIL beat%0d got f=%h c=%b eq=%b last=%b exp f=%h c=%b eq=%b last=%b", rcv,
                   out_f, out_c_out, out_a_eq_b, out_last, exp_f[rcv], exp_c[rcv], exp_eq[rcv], rcv == nb - 1);
        end
        if (rcv == nb - 1) begin
          checks++;
          if (out_overflow !== exp_ov) begin
            failures++;
            $display("FAIL overflow got=%b exp=%b", out_overflow, exp_ov);
          end
          got_ov = out_overflow;
        end
        got_f[rcv] = out_f; got_c[rcv] = out_c_out; got_eq[rcv] = out_a_eq_b;
        rcv++;
        lastc = cyc;
      end
      hold = out_valid && !out_ready;
      hold_f = out_f;
      if (in_valid && in_ready) begin
        if (first < 0) first = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (rcv != nb) begin
      failures++;
      $display("FAIL op_timeout got=%0d beats exp=%0d", rcv, nb);
    end
    got_n = rcv;
    span = lastc - first;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, in_ready, out_valid, out_f, out_last, out_c_out, out_a_eq_b, out_overflow} !== 15'd0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0", {cmd_ready, in_ready, out_valid, out_f, out_last, out_c_out, out_a_eq_b, out_overflow});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready got cmd=%b in=%b exp cmd=1 in=0", cmd_ready, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(4'b1001, 1'b0, 1'b0, 4'd2, 128'h00FF, 128'h0001, 100, 100);
    checks++;
    if ({got_f[0], got_c[0], got_f[1], got_c[1], got_ov} !== {8'h00, 1'b1, 8'h01, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL add16 got %h/%b %h/%b ov=%b exp 00/1 01/0 ov=0", got_f[0], got_c[0], got_f[1], got_c[1], got_ov);
    end
    run_op(4'b1001, 1'b0, 1'b0, 4'd1, 128'h7F, 128'h01, 100, 100);
    checks++;
    if ({got_f[0], got_c[0], got_ov} !== {8'h80, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_ovf got f=%h c=%b ov=%b exp f=80 c=0 ov=1", got_f[0], got_c[0], got_ov);
    end
    run_op(4'b0110, 1'b0, 1'b1, 4'd2, 128'h0100, 128'h0001, 100, 100);
    checks++;
    if ({got_f[0], got_f[1], got_ov} !== {8'hFF, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL sub16 got %h %h ov=%b exp FF 00 ov=0", got_f[0], got_f[1], got_ov);
    end
    run_op(4'b1001, 1'b0, 1'b0, 4'd4, 128'h89ABCDEF, 128'h76543211, 100, 40);
    run_op(4'b0110, 1'b1, 1'b0, 4'd3, 128'hAA0FFF, 128'h55F000, 100, 100);
    checks++;
    if ({got_f[0], got_f[1], got_f[2], got_eq[2], got_ov} !== {8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL xor24 got %h %h %h eq=%b ov=%b exp FF FF FF eq=1 ov=0", got_f[0], got_f[1], got_f[2], got_eq[2], got_ov);
    end
    run_op(4'b1001, 1'b0, 1'b0, 4'd0, 128'h05, 128'h03, 100, 100);
    checks++;
    if (got_n != 1 || got_f[0] !== 8'h08) begin
      failures++;
      $display("FAIL len0 got n=%0d f=%h exp n=1 f=08", got_n, got_f[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'b1001, 1'b0, 1'b1, 4'd4, 128'h12345678, 128'h9ABCDEF0, 100, 100);
    checks++;
    if (span != 4) begin
      failures++;
      $display("FAIL throughput got span=%0d exp=4", span);
    end
  endtask

  task automatic test_random();
    logic [127:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             LEN_W'($urandom_range(15)), a, b, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
    end
  endtask

  task automatic test_kill_mid();
    int n = 0;
    int fired = 0;
    send_cmd(4'b1001, 1'b0, 1'b1, 4'd4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (fired < 2 && n < 50) begin
      in_a = 8'($urandom());
      in_b = 8'($urandom());
      @(negedge clk);
      if (in_valid && in_ready) fired++;
      @(posedge clk); #1;
      n++;
    end
`ifdef ULA_SERIAL_ABORT_EN
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_blocks_in got=%b exp=0", in_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0;
`else
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got cmd=%b in=%b exp 0 0", cmd_ready, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL kill_state got v=%b cmd=%b exp v=0 cmd=1", out_valid, cmd_ready);
    end
    @(posedge clk); #1;
    run_op(4'b0110, 1'b0, 1'b1, 4'd2, 128'h0100, 128'h0001, 100, 100);
    checks++;
    if ({got_f[0], got_f[1]} !== {8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL after_kill got %h %h exp FF 00", got_f[0], got_f[1]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_kill_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
